// File: rtl/alu_op_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit ALU datapath: decode, operand
// read, execute (single-cycle, MUL latency, DIV handshake), and register write-back.
module alu_op_sequencer #(
   parameter int unsigned MUL_LAT     = 2,
   parameter int unsigned DIV_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   output logic [4:0]  rf_raddr_a,
   output logic [4:0]  rf_raddr_b,
   output logic        op_valid,
   output logic [5:0]  alu_sel,
   input  logic [15:0] alu_result,
   input  logic [31:0] mul_result,
   output logic        div_start,
   input  logic        div_done,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [15:0] rf_wdata,
   output logic        done,
   output logic        err
);

   localparam int unsigned CNT_MAX = (MUL_LAT > DIV_TIMEOUT) ? MUL_LAT : DIV_TIMEOUT;
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   localparam logic [5:0] OP_MUL = 6'b000111;
   localparam logic [5:0] OP_DIV = 6'b001000;

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_EXEC, S_WB_LO, S_WB_HI, S_ERR
   } state_t;

   state_t        state, state_d;
   logic [4:0]    rdst1, rdst1_d, rdst2, rdst2_d;
   logic [15:0]   prod_hi, prod_hi_d;
   logic [CW-1:0] cnt, cnt_d;

   logic          instr_ready_d, op_valid_d, div_start_d, rf_we_d, done_d, err_d;
   logic [4:0]    raddr_a_d, raddr_b_d, rf_waddr_d;
   logic [5:0]    alu_sel_d;
   logic [15:0]   rf_wdata_d;
   logic          accept;

   // Immediate/function bits of the word are not used by this datapath.
   logic unused_instr;
   assign unused_instr = ^instr[15:10];

   assign accept = instr_valid && instr_ready;

   function automatic logic is_legal(input logic [5:0] op);
      case (op)
         6'b000000, 6'b000100, 6'b000101, 6'b000110, 6'b000111,
         6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b001100,
         6'b001101, 6'b001110, 6'b001111, 6'b010000: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         instr_ready <= 1'b1;
         rf_raddr_a  <= '0;
         rf_raddr_b  <= '0;
         op_valid    <= 1'b0;
         alu_sel     <= '0;
         div_start   <= 1'b0;
         rf_we       <= 1'b0;
         rf_waddr    <= '0;
         rf_wdata    <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         rdst1       <= '0;
         rdst2       <= '0;
         prod_hi     <= '0;
         cnt         <= '0;
      end else begin
         state       <= state_d;
         instr_ready <= instr_ready_d;
         rf_raddr_a  <= raddr_a_d;
         rf_raddr_b  <= raddr_b_d;
         op_valid    <= op_valid_d;
         alu_sel     <= alu_sel_d;
         div_start   <= div_start_d;
         rf_we       <= rf_we_d;
         rf_waddr    <= rf_waddr_d;
         rf_wdata    <= rf_wdata_d;
         done        <= done_d;
         err         <= err_d;
         rdst1       <= rdst1_d;
         rdst2       <= rdst2_d;
         prod_hi     <= prod_hi_d;
         cnt         <= cnt_d;
      end
   end

   // Outputs are computed for the next state so they line up with it once registered.
   always_comb begin
      state_d       = state;
      instr_ready_d = 1'b0;
      raddr_a_d     = rf_raddr_a;
      raddr_b_d     = rf_raddr_b;
      op_valid_d    = 1'b0;
      alu_sel_d     = alu_sel;
      div_start_d   = 1'b0;
      rf_we_d       = 1'b0;
      rf_waddr_d    = rf_waddr;
      rf_wdata_d    = rf_wdata;
      done_d        = 1'b0;
      err_d         = 1'b0;
      rdst1_d       = rdst1;
      rdst2_d       = rdst2;
      prod_hi_d     = prod_hi;
      cnt_d         = cnt;

      case (state)
         S_IDLE: begin
            if (accept) begin
               alu_sel_d = instr[31:26];
               rdst2_d   = instr[25:21];
               rdst1_d   = instr[20:16];
               raddr_b_d = instr[9:5];
               raddr_a_d = instr[4:0];
               if (is_legal(instr[31:26])) begin
                  state_d = S_READ;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
               end
            end else begin
               instr_ready_d = 1'b1;
            end
         end
         S_READ: begin
            state_d     = S_EXEC;
            op_valid_d  = 1'b1;
            cnt_d       = '0;
            div_start_d = (alu_sel == OP_DIV);
         end
         S_EXEC: begin
            cnt_d = cnt + CW'(1);
            if (alu_sel == OP_MUL) begin
               if (cnt == CW'(MUL_LAT - 1)) begin
                  state_d    = S_WB_LO;
                  rf_we_d    = 1'b1;
                  rf_waddr_d = rdst1;
                  rf_wdata_d = mul_result[15:0];
                  prod_hi_d  = mul_result[31:16];
               end else begin
                  op_valid_d = 1'b1;
               end
            end else if (alu_sel == OP_DIV) begin
               if (div_done) begin
                  state_d    = S_WB_LO;
                  rf_we_d    = 1'b1;
                  rf_waddr_d = rdst1;
                  rf_wdata_d = alu_result;
                  done_d     = 1'b1;
               end else if (cnt == CW'(DIV_TIMEOUT - 1)) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  op_valid_d = 1'b1;
               end
            end else begin
               state_d    = S_WB_LO;
               rf_we_d    = 1'b1;
               rf_waddr_d = rdst1;
               rf_wdata_d = alu_result;
               done_d     = 1'b1;
            end
         end
         S_WB_LO: begin
            if (alu_sel == OP_MUL) begin
               state_d    = S_WB_HI;
               rf_we_d    = 1'b1;
               rf_waddr_d = rdst2;
               rf_wdata_d = prod_hi;
               done_d     = 1'b1;
            end else begin
               state_d       = S_IDLE;
               instr_ready_d = 1'b1;
            end
         end
         S_WB_HI, S_ERR: begin
            state_d       = S_IDLE;
            instr_ready_d = 1'b1;
         end
         default: begin
            state_d       = S_IDLE;
            instr_ready_d = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: bench-side register file, ALU and divider
// stubs; a reference model predicts writes, retire timing and error pulses.
module tb_alu_op_sequencer;

   localparam int unsigned MUL_LAT     = 2;
   localparam int unsigned DIV_TIMEOUT = 64;

   localparam logic [5:0] OP_MOV  = 6'b000000;
   localparam logic [5:0] OP_ADD  = 6'b000100;
   localparam logic [5:0] OP_SUB  = 6'b000101;
   localparam logic [5:0] OP_NEG  = 6'b000110;
   localparam logic [5:0] OP_MUL  = 6'b000111;
   localparam logic [5:0] OP_DIV  = 6'b001000;
   localparam logic [5:0] OP_OR   = 6'b001001;
   localparam logic [5:0] OP_XOR  = 6'b001010;
   localparam logic [5:0] OP_NAND = 6'b001011;
   localparam logic [5:0] OP_NOR  = 6'b001100;
   localparam logic [5:0] OP_XNOR = 6'b001101;
   localparam logic [5:0] OP_NOT  = 6'b001110;
   localparam logic [5:0] OP_LLSH = 6'b001111;
   localparam logic [5:0] OP_LRSH = 6'b010000;

   typedef struct {
      logic [4:0]  addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      bit err;
      int lat;
      int opv;
   } dn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic [4:0]  rf_raddr_a, rf_raddr_b;
   logic        op_valid;
   logic [5:0]  alu_sel;
   logic [15:0] alu_result;
   logic [31:0] mul_result;
   logic        div_start;
   logic        div_done;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   alu_op_sequencer #(.MUL_LAT(MUL_LAT), .DIV_TIMEOUT(DIV_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .op_valid(op_valid), .alu_sel(alu_sel), .alu_result(alu_result),
      .mul_result(mul_result), .div_start(div_start), .div_done(div_done),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .done(done), .err(err)
   );

   function automatic logic [15:0] alu_f(input logic [5:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
      case (op)
         OP_MOV:  return a;
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_NEG:  return 16'd0 - a;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_NAND: return ~(a & b);
         OP_NOR:  return ~(a | b);
         OP_XNOR: return ~(a ^ b);
         OP_NOT:  return ~a;
         OP_LLSH: return a << b[3:0];
         OP_LRSH: return a >> b[3:0];
         OP_DIV:  return (b == 16'd0) ? 16'hFFFF : a / b;
         default: return 16'd0;
      endcase
   endfunction

   // Register file with one-cycle read latency plus a backdoor preload port.
   logic [15:0] tb_rf [32];
   logic [15:0] rf_rdata_a, rf_rdata_b;
   logic        pl_we;
   logic [4:0]  pl_addr;
   logic [15:0] pl_data;

   always @(posedge clk) begin
      rf_rdata_a <= tb_rf[rf_raddr_a];
      rf_rdata_b <= tb_rf[rf_raddr_b];
      if (pl_we)      tb_rf[pl_addr]  <= pl_data;
      else if (rf_we) tb_rf[rf_waddr] <= rf_wdata;
   end

   always_comb begin
      alu_result = alu_f(alu_sel, rf_rdata_a, rf_rdata_b);
      mul_result = 32'(rf_rdata_a) * 32'(rf_rdata_b);
   end

   // Divider stub: div_done comes div_delay cycles after div_start (negative: never).
   int div_delay;
   int dv_k, dv_lim;
   bit dv_active;
   initial begin
      div_done  = 1'b0;
      dv_active = 1'b0;
      dv_k      = 0;
      dv_lim    = 0;
      forever begin
         @(negedge clk);
         if (div_start) begin
            dv_k      = 1;
            dv_lim    = div_delay;
            dv_active = (div_delay != 0);
            div_done  = (div_delay == 0);
         end else if (dv_active) begin
            div_done = (dv_k == dv_lim);
            if (div_done) dv_active = 1'b0;
            dv_k = dv_k + 1;
         end else begin
            div_done = 1'b0;
         end
      end
   end

   wr_t         wr_q[$];
   dn_t         dn_q[$];
   logic [15:0] ref_rf [32];
   int          exp_ds = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   bit          end_req = 1'b0;
   bit          end_ack = 1'b0;

   task automatic check(input string name, input bit ok, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Monitor: pops expectations whenever the DUT writes or retires.
   int  cyc = 0, acc = 0, opv = 0, ds_count = 0;
   bit  pending = 1'b0, prev_done = 1'b0, prev_rst = 1'b0, prev_ds = 1'b0;
   initial begin
      wr_t w;
      dn_t d;
      forever begin
         @(negedge clk);
         cyc++;
         if (prev_rst) begin
            check("reset_ctrl", {instr_ready, op_valid, div_start, rf_we, done, err} == 6'b100000,
                  32'({instr_ready, op_valid, div_start, rf_we, done, err}), 32'(6'b100000));
            check("reset_addr", {alu_sel, rf_raddr_a, rf_raddr_b, rf_waddr} == 21'd0,
                  32'({alu_sel, rf_raddr_a, rf_raddr_b, rf_waddr}), 32'd0);
            check("reset_wdata", rf_wdata == 16'd0, 32'(rf_wdata), 32'd0);
         end
         if (rf_we) begin
            if (wr_q.size() == 0) begin
               check("unexpected_write", 1'b0, 32'(rf_waddr), 32'd0);
            end else begin
               w = wr_q.pop_front();
               check("write_addr", rf_waddr == w.addr, 32'(rf_waddr), 32'(w.addr));
               check("write_data", rf_wdata == w.data, 32'(rf_wdata), 32'(w.data));
            end
         end
         if (div_start) begin
            check("div_start_pulse", !prev_ds, 32'(prev_ds), 32'd0);
            ds_count++;
         end
         if (op_valid) opv++;
         if (done) begin
            if (dn_q.size() == 0) begin
               check("unexpected_done", 1'b0, 32'd1, 32'd0);
            end else begin
               d = dn_q.pop_front();
               check("done_err", err == d.err, 32'(err), 32'(d.err));
               check("latency", pending && (cyc - acc == d.lat), 32'(cyc - acc), 32'(d.lat));
               check("op_valid_cycles", opv == d.opv, 32'(opv), 32'(d.opv));
            end
            pending = 1'b0;
         end else if (err) begin
            check("err_without_done", 1'b0, 32'(done), 32'd1);
         end
         if (prev_done) check("ready_after_done", instr_ready, 32'(instr_ready), 32'd1);
         if (instr_valid && instr_ready && !rst) begin
            check("accept_while_busy", !pending, 32'(pending), 32'd0);
            pending = 1'b1;
            acc     = cyc;
            opv     = 0;
         end
         if (rst) pending = 1'b0;
         if (end_req && !end_ack) begin
            check("writes_drained", wr_q.size() == 0, 32'(wr_q.size()), 32'd0);
            check("dones_drained", dn_q.size() == 0, 32'(dn_q.size()), 32'd0);
            check("div_start_count", ds_count == exp_ds, 32'(ds_count), 32'(exp_ds));
            end_ack = 1'b1;
         end
         prev_done = done;
         prev_rst  = rst;
         prev_ds   = div_start;
      end
   end

   function automatic bit legal(input logic [5:0] op);
      return op inside {OP_MOV, OP_ADD, OP_SUB, OP_NEG, OP_MUL, OP_DIV, OP_OR, OP_XOR,
                        OP_NAND, OP_NOR, OP_XNOR, OP_NOT, OP_LLSH, OP_LRSH};
   endfunction

   task automatic preload(input logic [4:0] a, input logic [15:0] d);
      pl_we   = 1'b1;
      pl_addr = a;
      pl_data = d;
      ref_rf[a] = d;
      @(posedge clk); #1;
      pl_we = 1'b0;
   endtask

   task automatic issue(input logic [31:0] w, input bit keep);
      instr_valid = 1'b1;
      instr       = w;
      for (int t = 0; !instr_ready; t++) begin
         if (t > 200) begin
            $display("FAIL issue_wait: instr_ready 0 for %0d cycles, expected 1", t);
            $fatal(1);
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      if (!keep) instr_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int t = 0; !instr_ready; t++) begin
         if (t > 200) begin
            $display("FAIL idle_wait: instr_ready 0 for %0d cycles, expected 1", t);
            $fatal(1);
         end
         @(posedge clk); #1;
      end
   endtask

   // Reference model: predicts the architectural effect of one instruction.
   task automatic do_instr(input logic [5:0] op, input logic [4:0] rd2, input logic [4:0] rd1,
                           input logic [4:0] rs2, input logic [4:0] rs1, input int dly,
                           input bit keep, input bit rst_wb);
      logic [15:0] a, b, r;
      logic [31:0] p;
      a = ref_rf[rs1];
      b = ref_rf[rs2];
      div_delay = dly;
      if (!legal(op)) begin
         dn_q.push_back('{err: 1'b1, lat: 1, opv: 0});
      end else if (op == OP_MUL) begin
         p = 32'(a) * 32'(b);
         wr_q.push_back('{addr: rd1, data: p[15:0]});
         ref_rf[rd1] = p[15:0];
         if (!rst_wb) begin
            wr_q.push_back('{addr: rd2, data: p[31:16]});
            ref_rf[rd2] = p[31:16];
            dn_q.push_back('{err: 1'b0, lat: 3 + int'(MUL_LAT), opv: int'(MUL_LAT)});
         end
      end else if (op == OP_DIV) begin
         exp_ds++;
         if (dly < 0 || dly >= int'(DIV_TIMEOUT)) begin
            dn_q.push_back('{err: 1'b1, lat: 2 + int'(DIV_TIMEOUT), opv: int'(DIV_TIMEOUT)});
         end else begin
            r = (b == 16'd0) ? 16'hFFFF : a / b;
            wr_q.push_back('{addr: rd1, data: r});
            ref_rf[rd1] = r;
            dn_q.push_back('{err: 1'b0, lat: 3 + dly, opv: dly + 1});
         end
      end else begin
         r = alu_f(op, a, b);
         wr_q.push_back('{addr: rd1, data: r});
         ref_rf[rd1] = r;
         dn_q.push_back('{err: 1'b0, lat: 3, opv: 1});
      end
      issue({op, rd2, rd1, 6'($urandom), rs2, rs1}, keep);
      if (rst_wb) begin
         for (int t = 0; !rf_we; t++) begin
            if (t > 50) begin
               $display("FAIL wb_wait: rf_we 0 for %0d cycles, expected 1", t);
               $fatal(1);
            end
            @(posedge clk); #1;
         end
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
      end
   endtask

   initial begin
      logic [5:0] ops [14];
      logic [5:0] op;
      ops = '{OP_MOV, OP_ADD, OP_SUB, OP_NEG, OP_MUL, OP_DIV, OP_OR, OP_XOR,
              OP_NAND, OP_NOR, OP_XNOR, OP_NOT, OP_LLSH, OP_LRSH};
      rst = 1'b1; instr_valid = 1'b0; instr = '0;
      pl_we = 1'b0; pl_addr = '0; pl_data = '0; div_delay = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 32; i++) preload(5'(i), 16'($urandom));

      preload(5'd1, 16'd5); preload(5'd2, 16'd3);
      do_instr(OP_ADD, 5'd0, 5'd4, 5'd1, 5'd2, 0, 1'b0, 1'b0);
      wait_idle();
      preload(5'd1, 16'h0100); preload(5'd2, 16'h0300);
      do_instr(OP_MUL, 5'd6, 5'd7, 5'd1, 5'd2, 0, 1'b0, 1'b0);
      wait_idle();
      do_instr(OP_MUL, 5'd9, 5'd9, 5'd2, 5'd2, 0, 1'b0, 1'b0);
      wait_idle();
      preload(5'd3, 16'd100); preload(5'd4, 16'd7); preload(5'd5, 16'd0);
      do_instr(OP_DIV, 5'd0, 5'd10, 5'd4, 5'd3, 5, 1'b0, 1'b0);
      wait_idle();
      do_instr(OP_DIV, 5'd0, 5'd11, 5'd4, 5'd3, -1, 1'b0, 1'b0);
      wait_idle();
      do_instr(OP_DIV, 5'd0, 5'd12, 5'd5, 5'd3, 0, 1'b0, 1'b0);
      wait_idle();
      do_instr(6'b000011, 5'd0, 5'd13, 5'd1, 5'd2, 0, 1'b0, 1'b0);
      wait_idle();
      do_instr(OP_ADD, 5'd0, 5'd14, 5'd1, 5'd2, 0, 1'b1, 1'b0);
      do_instr(OP_NOT, 5'd0, 5'd15, 5'd0, 5'd14, 0, 1'b0, 1'b0);
      wait_idle();
      do_instr(OP_MUL, 5'd16, 5'd17, 5'd3, 5'd4, 0, 1'b0, 1'b1);
      wait_idle();

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 14) == 0) begin
            do op = 6'($urandom_range(0, 63)); while (legal(op));
         end else begin
            op = ops[$urandom_range(0, 13)];
         end
         do_instr(op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  int'($urandom_range(0, 6)), 1'b0, 1'b0);
         wait_idle();
      end

      repeat (4) @(posedge clk);
      end_req = 1'b1;
      for (int t = 0; !end_ack; t++) begin
         if (t > 10) begin
            $display("FAIL end_wait: monitor did not respond");
            $fatal(1);
         end
         @(posedge clk);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
